// File: rtl/trap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trap_pkg
// Purpose  : Shared privilege, interrupt-code, FSM and tvec constants.
// Revision : 1.0
// ============================================================================
package trap_pkg;

  // One-hot privilege encoding used across the status/trap datapath
  localparam logic [3:0] PRIV_M = 4'b1000;
  localparam logic [3:0] PRIV_S = 4'b0010;
  localparam logic [3:0] PRIV_U = 4'b0001;

  localparam int         IRQ_W   = 12;
  localparam logic [3:0] IRQ_SSI = 4'd1;
  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_STI = 4'd5;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_SEI = 4'd9;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  localparam int         N_PRIO = 6;
  localparam logic [3:0] IRQ_PRIO [N_PRIO] = '{IRQ_MEI, IRQ_MSI, IRQ_MTI,
                                               IRQ_SEI, IRQ_SSI, IRQ_STI};

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_FLUSH    = 2'd1;
  localparam state_t ST_REDIRECT = 2'd2;

  localparam logic [1:0] TVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] TVEC_MODE_VECTORED = 2'b01;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } irq_pick_t;

  // Walk the list lowest priority first so the highest-priority hit is the last write
  function automatic irq_pick_t irq_pick(input logic [IRQ_W-1:0] set);
    irq_pick_t r;
    r = '0;
    for (int i = N_PRIO - 1; i >= 0; i--) begin
      if (set[IRQ_PRIO[i]]) begin
        r.valid = 1'b1;
        r.code  = IRQ_PRIO[i];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trap_irq_sel.sv
`default_nettype none
// ============================================================================
// Module   : trap_irq_sel
// Purpose  : Interrupt eligibility against privilege/enables/delegation plus
//            fixed-priority selection; M-level candidates beat S-level ones.
// Revision : 1.0
// ============================================================================
module trap_irq_sel
  import trap_pkg::*;
(
  input  logic [3:0]       priv,
  input  logic             mie,
  input  logic             sie,
  input  logic [IRQ_W-1:0] mip,
  input  logic [IRQ_W-1:0] mie_en,
  input  logic [IRQ_W-1:0] mideleg,
  output logic             irq_take,
  output logic [3:0]       irq_code,
  output logic             irq_to_s
);

  logic             m_enabled;
  logic             s_enabled;
  logic [IRQ_W-1:0] pend;
  logic [IRQ_W-1:0] m_set;
  logic [IRQ_W-1:0] s_set;
  irq_pick_t        m_pick;
  irq_pick_t        s_pick;

  always_comb begin
    pend      = mip & mie_en;
    m_enabled = (priv != PRIV_M) | mie;
    s_enabled = (priv == PRIV_U) | ((priv == PRIV_S) & sie);
    m_set     = pend & ~mideleg & {IRQ_W{m_enabled}};
    s_set     = pend &  mideleg & {IRQ_W{s_enabled}};
    m_pick    = irq_pick(m_set);
    s_pick    = irq_pick(s_set);
  end

  always_comb begin
    irq_take = 1'b0;
    irq_code = 4'd0;
    irq_to_s = 1'b0;
    if (m_pick.valid) begin
      irq_take = 1'b1;
      irq_code = m_pick.code;
    end else if (s_pick.valid) begin
      irq_take = 1'b1;
      irq_code = s_pick.code;
      irq_to_s = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl
// Purpose  : Trap entry controller: trap decision in WB, target-mode pulses,
//            cause/epc/tval latching and flush/redirect handshake.
// Revision : 1.0
// ============================================================================
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int EXC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       priv,
  input  logic             mie,
  input  logic             sie,
  input  logic [11:0]      mip,
  input  logic [11:0]      mie_en,
  input  logic [11:0]      mideleg,
  input  logic [EXC_W-1:0] medeleg,
  input  logic [XLEN-1:0]  mtvec,
  input  logic [XLEN-1:0]  stvec,
  input  logic             wb_valid,
  input  logic             wb_exc,
  input  logic [3:0]       wb_exc_code,
  input  logic [XLEN-1:0]  wb_pc,
  input  logic [XLEN-1:0]  wb_tval,
  input  logic             pipe_empty,
  input  logic             redirect_ready,
  output logic             trap_target_m,
  output logic             trap_target_s,
  output logic             trap_kill,
  output logic             pipe_flush,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [XLEN-1:0]  trap_cause,
  output logic [XLEN-1:0]  trap_epc,
  output logic [XLEN-1:0]  trap_tval,
  output logic             busy
);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]   epc_q,   epc_d;
  logic [XLEN-1:0]   tval_q,  tval_d;
  logic [XLEN-1:0]   rpc_q,   rpc_d;

  logic              irq_take;
  logic [3:0]        irq_code;
  logic              irq_to_s;

  logic              trap_take;
  logic              trap_is_irq;
  logic              trap_to_s;
  logic [3:0]        trap_code;
  logic [XLEN-1:0]   tvec;
  logic [XLEN-1:0]   vec_base;
  logic [XLEN-1:0]   vec_pc;
  logic [15:0]       medeleg_ext;

  trap_irq_sel u_irq_sel (
    .priv     (priv),
    .mie      (mie),
    .sie      (sie),
    .mip      (mip),
    .mie_en   (mie_en),
    .mideleg  (mideleg),
    .irq_take (irq_take),
    .irq_code (irq_code),
    .irq_to_s (irq_to_s)
  );

  // Exception codes are 4 bits wide, so only the low 16 delegation bits matter
  generate
    if (EXC_W >= 16) begin : g_deleg_trunc
      assign medeleg_ext = medeleg[15:0];
    end else begin : g_deleg_pad
      assign medeleg_ext = {{(16 - EXC_W){1'b0}}, medeleg};
    end
  endgenerate

  // Trap decision: a WB exception always beats any pending interrupt
  always_comb begin
    trap_take   = 1'b0;
    trap_is_irq = 1'b0;
    trap_to_s   = 1'b0;
    trap_code   = 4'd0;
    if (!rst && (state_q == ST_IDLE) && wb_valid) begin
      if (wb_exc) begin
        trap_take = 1'b1;
        trap_code = wb_exc_code;
        trap_to_s = medeleg_ext[wb_exc_code] & (priv != PRIV_M);
      end else if (irq_take) begin
        trap_take   = 1'b1;
        trap_is_irq = 1'b1;
        trap_code   = irq_code;
        trap_to_s   = irq_to_s;
      end
    end
  end

  always_comb begin
    tvec     = trap_to_s ? stvec : mtvec;
    vec_base = {tvec[XLEN-1:2], 2'b00};
    vec_pc   = vec_base;
    if (trap_is_irq && (tvec[1:0] == TVEC_MODE_VECTORED)) begin
      vec_pc = vec_base + {{(XLEN-6){1'b0}}, trap_code, 2'b00};
    end
  end

  always_comb begin
    cause_d = cause_q;
    epc_d   = epc_q;
    tval_d  = tval_q;
    rpc_d   = rpc_q;
    if (trap_take) begin
      cause_d            = '0;
      cause_d[XLEN-1]    = trap_is_irq;
      cause_d[3:0]       = trap_code;
      epc_d              = wb_pc;
      tval_d             = trap_is_irq ? '0 : wb_tval;
      rpc_d              = vec_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cause_q <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      tval_q  <= tval_d;
      rpc_q   <= rpc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (trap_take)      state_d = ST_FLUSH;
      ST_FLUSH:    if (pipe_empty)     state_d = ST_REDIRECT;
      ST_REDIRECT: if (redirect_ready) state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    trap_kill      = trap_take;
    trap_target_m  = trap_take & ~trap_to_s;
    trap_target_s  = trap_take &  trap_to_s;
    pipe_flush     = (state_q == ST_FLUSH);
    redirect_valid = (state_q == ST_REDIRECT);
    busy           = (state_q != ST_IDLE);
    redirect_pc    = rpc_q;
    trap_cause     = cause_q;
    trap_epc       = epc_q;
    trap_tval      = tval_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_ctrl
// Purpose  : Table-driven checks of trap_ctrl with a latched-value scoreboard.
// Revision : 1.0
// ============================================================================
module tb_trap_ctrl;

  localparam int XLEN  = 64;
  localparam int EXC_W = 16;
  localparam logic [3:0]  P_M = 4'b1000;
  localparam logic [3:0]  P_S = 4'b0010;
  localparam logic [3:0]  P_U = 4'b0001;
  localparam logic [63:0] IRQ = 64'h8000_0000_0000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       priv;
  logic             mie, sie;
  logic [11:0]      mip, mie_en, mideleg;
  logic [EXC_W-1:0] medeleg;
  logic [XLEN-1:0]  mtvec, stvec;
  logic             wb_valid, wb_exc;
  logic [3:0]       wb_exc_code;
  logic [XLEN-1:0]  wb_pc, wb_tval;
  logic             pipe_empty, redirect_ready;
  logic             trap_target_m, trap_target_s, trap_kill;
  logic             pipe_flush, redirect_valid, busy;
  logic [XLEN-1:0]  redirect_pc, trap_cause, trap_epc, trap_tval;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(XLEN), .EXC_W(EXC_W)) dut (
    .clk(clk), .rst(rst), .priv(priv), .mie(mie), .sie(sie), .mip(mip),
    .mie_en(mie_en), .mideleg(mideleg), .medeleg(medeleg), .mtvec(mtvec),
    .stvec(stvec), .wb_valid(wb_valid), .wb_exc(wb_exc),
    .wb_exc_code(wb_exc_code), .wb_pc(wb_pc), .wb_tval(wb_tval),
    .pipe_empty(pipe_empty), .redirect_ready(redirect_ready),
    .trap_target_m(trap_target_m), .trap_target_s(trap_target_s),
    .trap_kill(trap_kill), .pipe_flush(pipe_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_cause(trap_cause), .trap_epc(trap_epc), .trap_tval(trap_tval),
    .busy(busy)
  );

  typedef struct {
    logic [3:0]  priv;
    logic        mie, sie;
    logic [11:0] mip, mie_en, mideleg;
    logic [15:0] medeleg;
    logic [63:0] mtvec, stvec;
    logic        wbv, exc;
    logic [3:0]  code;
    logic [63:0] pc, tval;
    logic        take, to_s;
    logic [63:0] cause, rpc, etval;
  } vec_t;

  typedef struct {
    logic [63:0] cause, epc, tval, rpc;
  } exp_t;

  exp_t sb_q[$];
  vec_t vt[18];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(
    input logic [3:0] pv, input logic m_ie, input logic s_ie,
    input logic [11:0] ip, input logic [11:0] ie, input logic [11:0] ideleg,
    input logic [15:0] edeleg, input logic [63:0] mt, input logic [63:0] st,
    input logic wbv, input logic exc, input logic [3:0] code,
    input logic [63:0] pc, input logic [63:0] tval,
    input logic take, input logic to_s, input logic [63:0] cause,
    input logic [63:0] rpc, input logic [63:0] etval);
    vec_t v;
    v.priv = pv; v.mie = m_ie; v.sie = s_ie; v.mip = ip; v.mie_en = ie;
    v.mideleg = ideleg; v.medeleg = edeleg; v.mtvec = mt; v.stvec = st;
    v.wbv = wbv; v.exc = exc; v.code = code; v.pc = pc; v.tval = tval;
    v.take = take; v.to_s = to_s; v.cause = cause; v.rpc = rpc; v.etval = etval;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_pop_check(input string tag);
    exp_t e;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s_sb: redirect seen, expected nothing queued", tag);
    end else begin
      n_vec--;
      e = sb_q.pop_front();
      check({tag, "_cause"}, trap_cause,  e.cause);
      check({tag, "_epc"},   trap_epc,    e.epc);
      check({tag, "_tval"},  trap_tval,   e.tval);
      check({tag, "_rpc"},   redirect_pc, e.rpc);
    end
  endtask

  // Wait for the redirect of an already-decided trap, then for return to idle
  task automatic finish_trap(input string tag);
    bit seen = 1'b0;
    bit idle = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      wb_valid = 1'b0;
      wb_exc   = 1'b0;
      #2;
      if (redirect_valid) begin
        seen = 1'b1;
        sb_pop_check(tag);
      end
    end
    if (!seen) check({tag, "_redirect_timeout"}, 64'd0, 64'd1);
    for (int k = 0; k < 20 && !idle; k++) begin
      @(negedge clk);
      #2;
      if (!busy) idle = 1'b1;
    end
    if (!idle) check({tag, "_idle_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic apply(input vec_t v);
    priv = v.priv; mie = v.mie; sie = v.sie; mip = v.mip; mie_en = v.mie_en;
    mideleg = v.mideleg; medeleg = v.medeleg; mtvec = v.mtvec; stvec = v.stvec;
    wb_valid = v.wbv; wb_exc = v.exc; wb_exc_code = v.code; wb_pc = v.pc;
    wb_tval = v.tval;
  endtask

  initial begin
    int   flush_cnt, rv_cnt, kill_busy, rpc_moved;
    bit   done;
    logic [63:0] rpc_first;
    exp_t e;

    //          priv mie sie mip     mie_en  mideleg medeleg  mtvec          stvec          wbv exc code pc        tval      take s  cause      rpc            etval
    vt[0]  = mk(P_U, 0, 0, 12'h000, 12'h000, 12'h000, 16'h0100, 64'h4000_0000, 64'h8000_0000, 1, 1, 8, 64'h1000, 64'h55,  1, 1, 64'd8,     64'h8000_0000, 64'h55);
    vt[1]  = mk(P_M, 0, 0, 12'h000, 12'h000, 12'h000, 16'h0100, 64'h4000_0000, 64'h8000_0000, 1, 1, 8, 64'h1004, 64'h55,  1, 0, 64'd8,     64'h4000_0000, 64'h55);
    vt[2]  = mk(P_M, 0, 0, 12'h080, 12'h080, 12'h000, 16'h0000, 64'h1001,      64'h0,         1, 0, 0, 64'h1008, 64'h77,  0, 0, 64'd0,     64'h0,         64'h0);
    vt[3]  = mk(P_M, 1, 0, 12'h080, 12'h080, 12'h000, 16'h0000, 64'h1001,      64'h0,         1, 0, 0, 64'h100C, 64'h77,  1, 0, IRQ | 7,   64'h101C,      64'h0);
    vt[4]  = mk(P_S, 0, 1, 12'h0A0, 12'h0A0, 12'h020, 16'h0000, 64'h4000_0000, 64'h9000_0001, 1, 0, 0, 64'h1010, 64'h0,   1, 0, IRQ | 7,   64'h4000_0000, 64'h0);
    vt[5]  = mk(P_U, 0, 0, 12'h000, 12'h000, 12'h000, 16'h0000, 64'h4000_0000, 64'h0,         0, 1, 2, 64'h1014, 64'h0,   0, 0, 64'd0,     64'h0,         64'h0);
    vt[6]  = mk(P_S, 0, 0, 12'h000, 12'h000, 12'h000, 16'h0100, 64'h4000_0000, 64'h8000_0001, 1, 1, 8, 64'h1018, 64'hABC, 1, 1, 64'd8,     64'h8000_0000, 64'hABC);
    vt[7]  = mk(P_S, 0, 1, 12'h002, 12'h002, 12'h002, 16'h0000, 64'h4000_0000, 64'h2001,      1, 0, 0, 64'h101C, 64'h1,   1, 1, IRQ | 1,   64'h2004,      64'h0);
    vt[8]  = mk(P_S, 0, 0, 12'h002, 12'h002, 12'h002, 16'h0000, 64'h4000_0000, 64'h2001,      1, 0, 0, 64'h1020, 64'h1,   0, 0, 64'd0,     64'h0,         64'h0);
    vt[9]  = mk(P_U, 0, 0, 12'h002, 12'h002, 12'h002, 16'h0000, 64'h4000_0000, 64'h2001,      1, 0, 0, 64'h1024, 64'h1,   1, 1, IRQ | 1,   64'h2004,      64'h0);
    vt[10] = mk(P_M, 1, 1, 12'h002, 12'h002, 12'h002, 16'h0000, 64'h4000_0000, 64'h2001,      1, 0, 0, 64'h1028, 64'h1,   0, 0, 64'd0,     64'h0,         64'h0);
    vt[11] = mk(P_U, 0, 0, 12'h888, 12'h888, 12'h000, 16'h0000, 64'h1001,      64'h2001,      1, 0, 0, 64'h102C, 64'h0,   1, 0, IRQ | 11,  64'h102C,      64'h0);
    vt[12] = mk(P_U, 0, 0, 12'h088, 12'h088, 12'h000, 16'h0000, 64'h1001,      64'h2001,      1, 0, 0, 64'h1030, 64'h0,   1, 0, IRQ | 3,   64'h100C,      64'h0);
    vt[13] = mk(P_U, 0, 0, 12'h220, 12'h220, 12'h000, 16'h0000, 64'h1001,      64'h2001,      1, 0, 0, 64'h1034, 64'h0,   1, 0, IRQ | 9,   64'h1024,      64'h0);
    vt[14] = mk(P_S, 0, 1, 12'h280, 12'h280, 12'h200, 16'h0000, 64'h1001,      64'h2001,      1, 0, 0, 64'h1038, 64'h0,   1, 0, IRQ | 7,   64'h101C,      64'h0);
    vt[15] = mk(P_U, 0, 0, 12'h800, 12'h800, 12'h000, 16'h0000, 64'h1001,      64'h2001,      1, 1, 2, 64'h103C, 64'h33,  1, 0, 64'd2,     64'h1000,      64'h33);
    vt[16] = mk(P_U, 0, 0, 12'h800, 12'h800, 12'h000, 16'h0000, 64'h1001,      64'h2001,      1, 0, 0, 64'h1040, 64'h33,  1, 0, IRQ | 11,  64'h102C,      64'h0);
    vt[17] = mk(P_U, 0, 0, 12'h800, 12'h000, 12'h000, 16'h0000, 64'h1001,      64'h2001,      1, 0, 0, 64'h1044, 64'h0,   0, 0, 64'd0,     64'h0,         64'h0);

    rst = 1'b1;
    apply(mk(P_M, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    pipe_empty = 1'b0;
    redirect_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_busy",   {63'd0, busy},           64'd0);
    check("rst_flush",  {63'd0, pipe_flush},     64'd0);
    check("rst_rv",     {63'd0, redirect_valid}, 64'd0);
    check("rst_kill",   {63'd0, trap_kill},      64'd0);
    check("rst_cause",  trap_cause,              64'd0);
    check("rst_rpc",    redirect_pc,             64'd0);
    rst = 1'b0;
    pipe_empty = 1'b1;
    redirect_ready = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      apply(vt[i]);
      #2;
      check($sformatf("v%0d_kill", i), {63'd0, trap_kill},     {63'd0, vt[i].take});
      check($sformatf("v%0d_tm", i),   {63'd0, trap_target_m}, {63'd0, vt[i].take & ~vt[i].to_s});
      check($sformatf("v%0d_ts", i),   {63'd0, trap_target_s}, {63'd0, vt[i].take & vt[i].to_s});
      if (vt[i].take) begin
        e.cause = vt[i].cause; e.epc = vt[i].pc; e.tval = vt[i].etval; e.rpc = vt[i].rpc;
        sb_q.push_back(e);
        finish_trap($sformatf("v%0d", i));
      end
    end

    // Slow drain and slow redirect acceptance, with a new exception held in WB while busy
    @(negedge clk);
    apply(mk(P_M, 0, 0, 0, 0, 0, 0, 64'h3000, 0, 1, 1, 2, 64'h2000, 64'h99, 0, 0, 0, 0, 0));
    pipe_empty = 1'b0;
    redirect_ready = 1'b0;
    #2;
    check("hs_kill", {63'd0, trap_kill},     64'd1);
    check("hs_tm",   {63'd0, trap_target_m}, 64'd1);
    e.cause = 64'd2; e.epc = 64'h2000; e.tval = 64'h99; e.rpc = 64'h3000;
    sb_q.push_back(e);
    flush_cnt = 0; rv_cnt = 0; kill_busy = 0; rpc_moved = 0; done = 1'b0; rpc_first = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      #2;
      if (trap_kill | trap_target_m | trap_target_s) kill_busy++;
      if (pipe_flush) flush_cnt++;
      if (redirect_valid) begin
        if (rv_cnt == 0) begin
          sb_pop_check("hs");
          rpc_first = redirect_pc;
          wb_valid = 1'b0;
          wb_exc = 1'b0;
        end else if (redirect_pc !== rpc_first) begin
          rpc_moved++;
        end
        rv_cnt++;
      end
      if (!busy) done = 1'b1;
      pipe_empty     = (flush_cnt >= 6);
      redirect_ready = (rv_cnt >= 4);
    end
    check("hs_done",      {63'd0, done},  64'd1);
    check("hs_flush_cyc", 64'(flush_cnt), 64'd6);
    check("hs_rv_cyc",    64'(rv_cnt),    64'd4);
    check("hs_kill_busy", 64'(kill_busy), 64'd0);
    check("hs_rpc_moved", 64'(rpc_moved), 64'd0);

    // Reset while flushing
    @(negedge clk);
    apply(mk(P_U, 0, 0, 0, 0, 0, 0, 64'h5000, 0, 1, 1, 3, 64'h3000, 64'h44, 0, 0, 0, 0, 0));
    pipe_empty = 1'b0;
    redirect_ready = 1'b0;
    #2;
    check("rf_kill", {63'd0, trap_kill}, 64'd1);
    @(negedge clk);
    wb_valid = 1'b0;
    wb_exc = 1'b0;
    #2;
    check("rf_flush", {63'd0, pipe_flush}, 64'd1);
    check("rf_busy",  {63'd0, busy},       64'd1);
    check("rf_cause", trap_cause,          64'd3);
    check("rf_epc",   trap_epc,            64'h3000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    check("rf_busy0",  {63'd0, busy},           64'd0);
    check("rf_flush0", {63'd0, pipe_flush},     64'd0);
    check("rf_rv0",    {63'd0, redirect_valid}, 64'd0);
    check("rf_cause0", trap_cause,              64'd0);
    check("rf_epc0",   trap_epc,                64'd0);
    check("rf_tval0",  trap_tval,               64'd0);
    check("rf_rpc0",   redirect_pc,             64'd0);
    rst = 1'b0;
    pipe_empty = 1'b1;
    @(negedge clk);
    #2;
    check("rf_after", {63'd0, busy | pipe_flush | redirect_valid}, 64'd0);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap entry controller, directly upstream of the M/S status register block.
- Watches the WB stage for synchronous exceptions and evaluates pending interrupts against current privilege, mie/sie and delegation.
- Selects the target mode, emits one-cycle trap_target_m/trap_target_s pulses to the status block, and latches cause/epc/tval for the CSR file.
- Runs a flush/redirect handshake with the front end; the pipeline restarts at the trap vector.

Parameters:
- XLEN, 64, data/address width.
- EXC_W, 16, number of medeleg exception codes supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- priv  in  4  current privilege, one-hot: 1000=M, 0010=S, 0001=U
- mie  in  1  mstatus.MIE
- sie  in  1  mstatus.SIE
- mip  in  12  pending interrupt bits
- mie_en  in  12  mie CSR enable bits
- mideleg  in  12  interrupt delegation to S
- medeleg  in  EXC_W  exception delegation to S
- mtvec  in  XLEN  base[XLEN-1:2], mode[1:0]
- stvec  in  XLEN  same layout as mtvec
- wb_valid  in  1  instruction in WB is valid
- wb_exc  in  1  instruction in WB carries an exception
- wb_exc_code  in  4  exception code
- wb_pc  in  XLEN  PC of the WB instruction
- wb_tval  in  XLEN  faulting address/instruction
- pipe_empty  in  1  front end and pipeline drained
- redirect_ready  in  1  front end accepts redirect
- trap_target_m  out  1  one-cycle pulse: M takes trap
- trap_target_s  out  1  one-cycle pulse: S takes trap
- trap_kill  out  1  suppress WB retire this cycle
- pipe_flush  out  1  flush request, held until drained
- redirect_valid  out  1  vector PC valid
- redirect_pc  out  XLEN  trap vector
- trap_cause  out  XLEN  bit XLEN-1 = interrupt, low bits = code
- trap_epc  out  XLEN  latched wb_pc
- trap_tval  out  XLEN  latched wb_tval; 0 for interrupts
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; all outputs 0; latches cleared.

Interrupt eligibility (combinational, evaluated only when wb_valid in IDLE):
- pend = mip & mie_en.
- M-level set = pend & ~mideleg. Enabled if priv != M, or priv == M and mie.
- S-level set = pend & mideleg. Enabled if priv == U, or priv == S and sie. Never enabled when priv == M.
- Priority, first match wins: MEI(11), MSI(3), MTI(7), SEI(9), SSI(1), STI(5).
- Any enabled M-level interrupt beats any S-level interrupt.

Exception path:
- wb_valid & wb_exc beats every interrupt.
- Target is S if medeleg[wb_exc_code] and priv != M; otherwise target is M.

FSM states: IDLE, FLUSH, REDIRECT.
- IDLE, on trap decision (same cycle, combinational):
  - trap_kill=1.
  - Exactly one of trap_target_m/trap_target_s pulses for that single cycle.
  - Latch cause, epc=wb_pc, tval (wb_tval for exceptions, 0 for interrupts), target and redirect_pc.
  - Go to FLUSH.
- FLUSH: pipe_flush=1. When pipe_empty, go to REDIRECT. pipe_empty may already be 1 on FLUSH entry; minimum FLUSH occupancy is 1 cycle.
- REDIRECT:
  - redirect_valid=1; redirect_pc stays stable.
  - On redirect_ready, go to IDLE. pipe_flush and redirect_valid drop in the cycle after.
- While busy, no new traps are evaluated and trap_kill=0.

Vector:
- tvec = mtvec for M target, stvec for S target.
- mode == 01 and interrupt: base + 4*code. Otherwise: base (low 2 bits forced 0).
- Addition is XLEN wide; wrap-around is ignored.

Boundary cases:
- wb_exc without wb_valid: ignored.
- Interrupt and exception in the same cycle: exception is taken; the interrupt stays pending in mip.
- rst in any state: return to IDLE synchronously; pulses and valids drop the next cycle.
- mret/sret are handled in the status block; this block does not observe them.

Decomposition:
- Shared package trap_pkg:
  - privilege one-hot constants (M=1000, S=0010, U=0001);
  - interrupt codes (MSI=3, SSI=1, MTI=7, STI=5, MEI=11, SEI=9);
  - FSM state encoding;
  - tvec mode constants.
- One sub-module, trap_irq_sel: combinational eligibility plus priority encoder. Outputs irq_take, irq_code[3:0] and irq_to_s.

Test Plan:
- priv=U, wb_valid=1, wb_exc=1, code=8, medeleg[8]=1, stvec=0x8000_0000 -> same-cycle trap_target_s=1, trap_kill=1; then FLUSH; with pipe_empty, REDIRECT with redirect_pc=0x8000_0000; trap_cause=8, trap_epc=wb_pc.
- Same stimulus with priv=M -> trap_target_m=1, redirect to mtvec base (delegation ignored in M).
- priv=M, mie=0, mip[7]=mie_en[7]=1 -> no trap. Raise mie=1 -> trap_target_m; trap_cause=0x8000_0000_0000_0007. With mtvec=0x1001 (vectored), redirect_pc=0x101C; trap_tval=0.
- mip=mie_en=0x0A0 (MTI, STI), mideleg[5]=1, priv=S, sie=1 -> MTI taken to M, cause code 7.
- wb_exc code 2 plus pending MEI in the same cycle -> exception taken, cause=2. After return to IDLE, the next wb_valid takes MEI.
- pipe_empty held 0 for 5 cycles, then redirect_ready delayed 3 cycles -> pipe_flush high 6 cycles, redirect_valid high 4 cycles, redirect_pc stable. rst asserted mid-FLUSH -> all outputs 0 the next cycle, busy=0.
